// File: rtl/uart_rx_term_pkg.sv
// rtl/uart_rx_term_pkg.sv - shared FSM states, parity codes and counter width helper for uart_rx_term
package uart_rx_term_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Number of bits needed to hold every value 0..max_val (at least 1).
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word fall-through receive FIFO with level and drop indication
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             full, pop, wr_en;

  // Push/pop decisions; a pop on a full FIFO frees the slot for a same-cycle push.
  always_comb begin
    full     = (level_q == FULL_LVL);
    rd_valid = (level_q != '0);
    pop      = rd_valid & pop_ready;
    wr_en    = push & (~full | pop);
    drop     = push & full & ~pop;
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    hold_d   = pop ? mem_q[rd_ptr_q] : hold_q;
    rd_data  = rd_valid ? mem_q[rd_ptr_q] : hold_q;
    level    = level_q;
  end

  // Pointer, level and last-popped-character registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      hold_q   <= hold_d;
    end
  end

  // Storage array; contents are meaningless while level is zero, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_rx_term.sv
// rtl/uart_rx_term.sv - UART receive terminal with FWFT FIFO; UART_RX_TERM_MAJORITY_EN enables 3-tap majority sampling
module uart_rx_term
  import uart_rx_term_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          rx,
  input  logic                          en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  input  logic                          err_clr
);

  localparam int CW = cnt_width(CLK_DIV - 1);
  localparam int BW = cnt_width(DATA_BITS);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  logic rx_meta_q, rx_meta_d;
  logic rx_s_q, rx_s_d;
  logic rx_prev_q, rx_prev_d;
  logic fall, sample;

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 stop_bad_q, stop_bad_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;
  logic                 push, frame_evt, parity_evt, drop, exp_par;

`ifdef UART_RX_TERM_MAJORITY_EN
  logic rx_d2_q, rx_d2_d;

  // Third tap for the vote; the window is centred on rx_prev so every tap is a settled flop and the decision cycle is unchanged.
  always_comb begin
    rx_d2_d = rx_prev_q;
    sample  = (rx_s_q & rx_prev_q) | (rx_s_q & rx_d2_q) | (rx_prev_q & rx_d2_q);
  end

  // Extra delay tap, idles high like the line.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) rx_d2_q <= 1'b1;
    else          rx_d2_q <= rx_d2_d;
  end
`else
  // Single-point sampling of the synchronised line.
  always_comb begin
    sample = rx_s_q;
  end
`endif

  // Synchroniser next values and start-edge detect.
  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    rx_prev_d = rx_s_q;
    fall      = ~rx_s_q & rx_prev_q;
  end

  // Two-flop synchroniser plus previous value for edge detection; idle high.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      rx_prev_q <= rx_prev_d;
    end
  end

  // Frame FSM: bit timing, shifting, parity/stop checking and push decision.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    stop_bad_d = stop_bad_q;
    push       = 1'b0;
    frame_evt  = 1'b0;
    parity_evt = 1'b0;
    exp_par    = (PARITY == PAR_ODD) ? ~^shift_q : ^shift_q;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      bit_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d      = '0;
          bit_d      = '0;
          par_bad_d  = 1'b0;
          stop_bad_d = 1'b0;
          if (fall) state_d = ST_START;
        end
        ST_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_d   = '0;
            state_d = sample ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d   = '0;
            shift_d = {sample, shift_q[DATA_BITS-1:1]};
            if (bit_q == DATA_LAST) begin
              bit_d   = '0;
              state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end
        end
        ST_PAR: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d     = '0;
            par_bad_d = (sample != exp_par);
            state_d   = ST_STOP;
          end
        end
        ST_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d = '0;
            if (!sample) stop_bad_d = 1'b1;
            if (bit_q == STOP_LAST) begin
              bit_d      = '0;
              state_d    = ST_IDLE;
              frame_evt  = stop_bad_q | ~sample;
              parity_evt = par_bad_q;
              push       = ~(stop_bad_q | ~sample) & ~par_bad_q;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sticky error flags; a new event in the clear cycle wins.
  always_comb begin
    frame_err_d  = (err_clr ? 1'b0 : frame_err_q)  | frame_evt;
    parity_err_d = (err_clr ? 1'b0 : parity_err_q) | parity_evt;
    overrun_d    = (err_clr ? 1'b0 : overrun_q)    | drop;
  end

  // Frame FSM and flag registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      stop_bad_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      stop_bad_q   <= stop_bad_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .push      (push),
    .push_data (shift_q),
    .pop_ready (rd_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .level     (fifo_level),
    .drop      (drop)
  );

endmodule

// File: doc/uart_rx_term.md
Name: uart_rx_term

Overview:
Synthesizable, parametrised UART receive terminal on one clock domain. It is the hardware successor to the behavioural serial terminal used on UART0 TX in SoC benches.
- Configurable frame format: data bits, parity, stop bits, bit period.
- Oversampled start-bit validation and error flags.
- Valid/ready FIFO read port.
- Sits on any UART TX line, in the SoC (debug/loopback receiver) or in DV as a checkable receiver.

Parameters:
CLK_DIV, 16, HCLK cycles per bit; even, >=4
DATA_BITS, 8, data bits per frame, 5..9, LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 8, receive FIFO entries, power of 2, >=2

Ports:
HCLK  input  1  clock; one clock for the whole block
HRESETn  input  1  reset, asynchronous assert, active-low
rx  input  1  serial line, asynchronous, idle high
en  input  1  receiver enable
rd_data  output  DATA_BITS  FIFO head character
rd_valid  output  1  FIFO not empty
rd_ready  input  1  consumer accepts rd_data
fifo_level  output  $clog2(FIFO_DEPTH)+1  entries held
frame_err  output  1  sticky: stop bit sampled 0
parity_err  output  1  sticky: parity mismatch
overrun  output  1  sticky: character dropped, FIFO full
err_clr  input  1  clears all sticky flags

Behaviour:
- Reset values: all outputs 0; rd_data 0; rx synchroniser flops 1; FSM IDLE; bit counter 0.
- Synchronisation: rx passes a 2-flop synchroniser (rx_s). A falling edge is rx_s = 0 with previous rx_s = 1.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: on a falling edge with en = 1 -> START, cycle counter cleared.
- START: at count CLK_DIV/2-1, sample rx_s.
  - Sample = 1: false start, -> IDLE, no flag.
  - Sample = 0: -> DATA.
- DATA: sample every CLK_DIV cycles, shifting LSB first. After DATA_BITS samples -> PAR if PARITY != 0, else -> STOP.
- PAR: one sample, compared against the odd/even parity of the data.
- STOP: STOP_BITS samples at CLK_DIV spacing. Any 0 sample marks a framing error. After the last sample -> IDLE in the same cycle the character is pushed.
- Push rules:
  - A frame with a framing or parity error is discarded and sets the matching sticky flag. Both flags may set on one frame.
  - A good frame is pushed. If the FIFO is full and no pop happens that cycle, the frame is dropped and overrun is set.
- Latency: rd_valid rises 2 + CLK_DIV/2 + (DATA_BITS + (PARITY != 0) + STOP_BITS)*CLK_DIV + 1 cycles after rx falls. For 8N1, CLK_DIV = 16, that is 155.
- FIFO: first-word fall-through. A pop occurs when rd_valid & rd_ready. rd_data holds its value while rd_valid = 0.
- Simultaneous events:
  - Push and pop while full: both occur, no overrun, level unchanged.
  - Push and pop while empty: push only.
  - Pointers wrap modulo FIFO_DEPTH.
- en = 0: FSM forced to IDLE next cycle and any partial frame is aborted with no flags. FIFO contents and the read port keep operating.
- Sticky flags: err_clr clears them. If err_clr coincides with a new error event, set wins.
- Reset asserted mid-frame or mid-read: everything returns to reset values immediately. FIFO is emptied.

Optional Feature:
- Macro: UART_RX_TERM_MAJORITY_EN.
- Defined: every START/DATA/PAR/STOP sample is the 2-of-3 majority of rx_s at sample point -1, 0 and +1 cycle. A single-cycle glitch cannot corrupt a bit, and latency is unchanged.
- Undefined: single sample at the sample point; a 1-cycle glitch on the sample point is captured.

Decomposition:
- Package uart_rx_term_pkg holds:
  - FSM state enum.
  - Parity encodings PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2.
  - Width helper function for the counters.
- One sub-module: uart_rx_fifo, a parametrised synchronous FWFT FIFO (WIDTH, DEPTH) with level output.

Test Plan:
- 8N1, CLK_DIV = 16, send 0x41 then 0x0A, rd_ready = 1 -> rd_data 0x41 then 0x0A. First rd_valid exactly 155 cycles after the rx fall; no flags set.
- PARITY = 2, send 0x5A with parity bit 1 (wrong) -> nothing pushed, parity_err = 1. Next frame 0x5A with parity 0 -> pushed. err_clr pulse -> parity_err = 0.
- Stop bit driven 0 on 0x33 -> frame_err = 1, FIFO empty. A 4-cycle low pulse on an idle line -> false start, no flags, FIFO empty.
- FIFO_DEPTH = 4, rd_ready = 0, send 0x01..0x05 -> fifo_level = 4, overrun = 1, reads return 0x01..0x04. Then raise rd_ready on the cycle the 5th push occurs -> no overrun, level stays 4.
- Drop en in the middle of the DATA bits, then raise it again and send 0x7E -> only 0x7E received, no flags. Assert HRESETn low mid-frame -> all outputs 0 immediately.
- With UART_RX_TERM_MAJORITY_EN, inject a 1-cycle high glitch at a data-bit sample point of 0x00 -> 0x00 received. Without the macro the same stimulus -> corrupted bit.
